bsg_mux_one_hot_rr_buf: RTL and testbench
=========================================

// Module: bsg_mux_one_hot_rr_buf
// PURPOSE
//  Registered N:1 channel mux with valid/ready handshakes. An internal round-robin
//  arbiter makes a one-hot grant, which drives a one-hot AND-OR mux. The winner is
//  captured into a single output register. Optional packet lock keeps the grant on a
//  channel until its last beat. Sits in front of shared links or FIFOs that merge
//  several producers.
// PARAMETERS
//  width_p          "inv"  payload bits per channel (>=1)
//  els_p            2      number of input channels (>=1)
//  lock_packets_p   0      1: hold grant on a channel until a beat with last_i=1 transfers
// PORTS
//  clk_i          in   1               clock
//  reset_n_i      in   1               async active-low reset
//  v_i            in   els_p           per-channel valid
//  data_i         in   els_p*width_p   per-channel payload, [els_p-1:0][width_p-1:0]
//  last_i         in   els_p           per-channel end-of-packet (ignored if lock_packets_p=0)
//  ready_o        out  els_p           per-channel ready; input transfer = v_i[i] & ready_o[i]
//  v_o            out  1               output register valid
//  data_o         out  width_p         output register payload
//  last_o         out  1               last flag of the registered beat
//  grant_o        out  els_p           one-hot source channel of the registered beat
//  ready_i        in   1               downstream ready; output transfer = v_o & ready_i
// BEHAVIOUR
//  - Reset (async assert, sync deassert by caller): v_o=0, data_o=0, last_o=0,
//    grant_o=0, priority pointer=0 (channel 0 highest), lock=0.
//  - Storage:
//    - One output register; enq_ok = ~v_o | ready_i (pass-through ready).
//    - Full throughput: one beat per cycle with ready_i held high.
//    - Latency: an input transfer in cycle n appears on v_o/data_o in cycle n+1.
//  - Arbitration (combinational, every cycle):
//    - Scan v_i from pointer p upward with wrap; the first valid channel wins.
//    - gnt is one-hot, or all-zero when no channel is valid.
//    - ready_o = gnt & {els_p{enq_ok}}. At most one ready_o bit is high; ready_o
//      never depends on ready_o.
//  - Mux: data = OR over i of (data_i[i] & {width_p{gnt[i]}}). Same for last.
//  - On an input transfer from channel g:
//    - capture data, last and gnt into data_o, last_o and grant_o;
//    - set v_o=1;
//    - p <= (g+1) mod els_p, unless the lock holds.
//  - Output transfer with no input transfer in the same cycle: v_o <= 0. data_o,
//    grant_o and last_o hold their old values.
//  - Simultaneous output and input transfer: the register reloads and v_o stays 1.
//  - Pointer:
//    - Changes only on an input transfer.
//    - Stalls (enq_ok=0) leave p and the grant choice stable.
//    - A channel whose v_i drops while stalled may lose the grant; there is no
//      starvation with stable valids.
//  - Packet lock (lock_packets_p=1):
//    - Transfer from g with last_i[g]=0 sets lock=1 and lock_ch=g.
//    - While locked, gnt = onehot(lock_ch) & v_i. If that channel is not valid, no
//      grant; other channels wait.
//    - Transfer with last_i[lock_ch]=1 clears the lock, and p <= lock_ch+1.
//  - lock_packets_p=0: last_i is passed through to last_o only; it has no effect on
//    arbitration.
//  - els_p=1: gnt = v_i, p is constant 0, ready_o = enq_ok.
//  - Invariant: grant_o is one-hot whenever v_o=1.
//  - Reset asserted mid-packet clears the lock and drops any held beat.
// TESTING
//  1. els_p=4, width_p=8, all v_i=1 with data_i[i]=8'h10+i, ready_i=1:
//     data_o sequence 10,11,12,13,10...; grant_o 0001,0010,0100,1000; one beat per cycle.
//  2. Backpressure: 3 beats queued, ready_i=0 for 5 cycles:
//     - v_o=1 and data_o stable;
//     - ready_o=0;
//     - pointer unchanged;
//     - on release the order resumes with no loss or duplicate.
//  3. Only ch2 valid, then ch0+ch2 valid: ch2 wins first, then ch0 (p=3 wraps to 0),
//     then ch2.
//  4. lock_packets_p=1: ch1 sends 3 beats (last on the 3rd) while ch0 and ch3 stay valid:
//     - output is ch1,ch1,ch1, then ch3;
//     - a 2-cycle gap in ch1 valid yields no grant to others.
//  5. Assert reset_n_i=0 mid-packet with v_o=1: v_o, grant_o and data_o go to 0
//     immediately (async); after release channel 0 has priority and the lock is clear.
//  6. Random v_i, last_i, ready_i for 10k cycles vs a scoreboard model:
//     - per-channel order is preserved;
//     - grant_o is one-hot when v_o=1;
//     - no channel waits more than els_p grants (unlocked mode).

Source files
------------

// File: rtl/bsg_mux_one_hot_rr_buf.sv
// bsg_mux_one_hot_rr_buf: registered N:1 round-robin mux with one-hot AND-OR select,
// valid/ready handshakes and optional packet lock.
module bsg_mux_one_hot_rr_buf #(
    parameter int width_p        = 8,
    parameter int els_p          = 2,
    parameter int lock_packets_p = 0
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic [els_p-1:0]                v_i,
    input  logic [els_p-1:0][width_p-1:0]   data_i,
    input  logic [els_p-1:0]                last_i,
    output logic [els_p-1:0]                ready_o,
    output logic                            v_o,
    output logic [width_p-1:0]              data_o,
    output logic                            last_o,
    output logic [els_p-1:0]                grant_o,
    input  logic                            ready_i
);
    localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;

    logic               v_q, v_d, last_q, last_d, lock_q, lock_d;
    logic [width_p-1:0] data_q, data_d;
    logic [els_p-1:0]   grant_q, grant_d;
    logic [ptr_w-1:0]   p_q, p_d, lock_ch_q, lock_ch_d;

    logic               enq_ok, found, xfer, mux_last;
    logic [els_p-1:0]   rot, rr_gnt, lock_gnt, gnt;
    logic [width_p-1:0] mux_data;
    logic [ptr_w-1:0]   g_idx;
    int                 sel, w;

    always_comb begin
        enq_ok = ~v_q | ready_i;
        // rotate valids so the pointer channel sits at bit 0, then find first set
        rot = els_p'({v_i, v_i} >> p_q);
        found = 1'b0;
        sel = 0;
        for (int i = 0; i < els_p; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                sel = i;
            end
        end
        w = int'(p_q) + sel;
        if (w >= els_p) w = w - els_p;
        for (int i = 0; i < els_p; i++) begin
            rr_gnt[i] = found && (w == i);
            lock_gnt[i] = v_i[i] && (lock_ch_q == ptr_w'(i));
        end
        gnt = (lock_packets_p != 0 && lock_q) ? lock_gnt : rr_gnt;
        ready_o = gnt & {els_p{enq_ok}};
        xfer = |(v_i & ready_o);
        mux_data = '0;
        mux_last = 1'b0;
        g_idx = '0;
        for (int i = 0; i < els_p; i++) begin
            mux_data = mux_data | (data_i[i] & {width_p{gnt[i]}});
            mux_last = mux_last | (last_i[i] & gnt[i]);
            if (gnt[i]) g_idx = ptr_w'(i);
        end
        v_d = v_q;
        data_d = data_q;
        last_d = last_q;
        grant_d = grant_q;
        p_d = p_q;
        lock_d = lock_q;
        lock_ch_d = lock_ch_q;
        if (xfer) begin
            v_d = 1'b1;
            data_d = mux_data;
            last_d = mux_last;
            grant_d = gnt;
            // a non-last beat pins the grant; the pointer moves only when the packet ends
            if (lock_packets_p != 0 && !mux_last) begin
                lock_d = 1'b1;
                lock_ch_d = g_idx;
            end else begin
                lock_d = 1'b0;
                p_d = (g_idx == ptr_w'(els_p - 1)) ? '0 : g_idx + 1'b1;
            end
        end else if (ready_i) begin
            v_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v_q       <= 1'b0;
            data_q    <= '0;
            last_q    <= 1'b0;
            grant_q   <= '0;
            p_q       <= '0;
            lock_q    <= 1'b0;
            lock_ch_q <= '0;
        end else begin
            v_q       <= v_d;
            data_q    <= data_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            p_q       <= p_d;
            lock_q    <= lock_d;
            lock_ch_q <= lock_ch_d;
        end
    end

    assign v_o     = v_q;
    assign data_o  = data_q;
    assign last_o  = last_q;
    assign grant_o = grant_q;
endmodule

// File: tb/tb_bsg_mux_one_hot_rr_buf.sv
// tb_bsg_mux_one_hot_rr_buf: unlocked and packet-locked instances driven with shared
// stimulus and compared every cycle against a channel-index reference model.
module tb_bsg_mux_one_hot_rr_buf;
    logic             clk = 1'b0;
    logic             reset_n_i = 1'b0;
    logic [3:0]       v_i = '0, last_i = '0;
    logic [3:0][7:0]  data_i = '0;
    logic             ready_i = 1'b0;
    logic [3:0]       ready_o [2];
    logic             v_o [2], last_o [2];
    logic [7:0]       data_o [2];
    logic [3:0]       grant_o [2];

    int vec = 0, err = 0;

    // reference state: index 0 = unlocked instance, 1 = locked instance
    bit       mv [2];
    bit [7:0] md [2];
    bit       ml [2];
    int       mg [2], mp [2], mch [2];
    bit       mlock [2];
    int       waits [4];

    always #5 clk = ~clk;

    bsg_mux_one_hot_rr_buf #(.width_p(8), .els_p(4), .lock_packets_p(0)) u0 (
        .clk_i(clk), .reset_n_i(reset_n_i), .v_i(v_i), .data_i(data_i), .last_i(last_i),
        .ready_o(ready_o[0]), .v_o(v_o[0]), .data_o(data_o[0]), .last_o(last_o[0]),
        .grant_o(grant_o[0]), .ready_i(ready_i));

    bsg_mux_one_hot_rr_buf #(.width_p(8), .els_p(4), .lock_packets_p(1)) u1 (
        .clk_i(clk), .reset_n_i(reset_n_i), .v_i(v_i), .data_i(data_i), .last_i(last_i),
        .ready_o(ready_o[1]), .v_o(v_o[1]), .data_o(data_o[1]), .last_o(last_o[1]),
        .grant_o(grant_o[1]), .ready_i(ready_i));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input int n);
        if (mlock[n]) return v_i[mch[n]] ? mch[n] : -1;
        for (int k = 0; k < 4; k++)
            if (v_i[(mp[n] + k) % 4]) return (mp[n] + k) % 4;
        return -1;
    endfunction

    function automatic logic [3:0] oh(input int c);
        return (c < 0) ? 4'b0000 : 4'(1 << c);
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            mv[n] = 0; md[n] = 0; ml[n] = 0; mg[n] = -1; mp[n] = 0; mlock[n] = 0; mch[n] = 0;
        end
        for (int c = 0; c < 4; c++) waits[c] = 0;
    endtask

    task automatic check_outputs();
        for (int n = 0; n < 2; n++) begin
            chk($sformatf("v_o[%0d]", n), 32'(v_o[n]), 32'(mv[n]));
            chk($sformatf("data_o[%0d]", n), 32'(data_o[n]), 32'(md[n]));
            chk($sformatf("last_o[%0d]", n), 32'(last_o[n]), 32'(ml[n]));
            chk($sformatf("grant_o[%0d]", n), 32'(grant_o[n]), 32'(oh(mg[n])));
            if (v_o[n]) chk($sformatf("onehot[%0d]", n), 32'($onehot(grant_o[n])), 32'd1);
        end
    endtask

    // apply one cycle of inputs, check ready_o, advance the model, check registered outputs
    task automatic step(input logic [3:0] v, input logic [3:0] l, input logic r,
                        input logic [31:0] d);
        int g;
        bit enq;
        v_i = v; last_i = l; ready_i = r; data_i = d;
        #1;
        for (int n = 0; n < 2; n++) begin
            g = pick(n);
            enq = !mv[n] || r;
            chk($sformatf("ready_o[%0d]", n), 32'(ready_o[n]), 32'(enq ? oh(g) : 4'b0));
            if (g >= 0 && enq) begin
                mv[n] = 1; md[n] = data_i[g]; ml[n] = l[g]; mg[n] = g;
                if (n == 1 && !l[g]) begin
                    mlock[n] = 1; mch[n] = g;
                end else begin
                    mlock[n] = 0; mp[n] = (g + 1) % 4;
                end
            end else if (r) begin
                mv[n] = 0;
            end
        end
        // fairness of the unlocked instance: a steadily valid channel sees at most 3 other grants
        for (int c = 0; c < 4; c++) begin
            if (!v[c] || ready_o[0][c]) waits[c] = 0;
            else if (ready_o[0] != 0) begin
                waits[c]++;
                chk($sformatf("starve ch%0d", c), 32'(waits[c] <= 3), 32'd1);
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        reset_n_i = 1'b0;
        #1;
        model_reset();
        for (int n = 0; n < 2; n++) begin
            chk($sformatf("rst v_o[%0d]", n), 32'(v_o[n]), 32'd0);
            chk($sformatf("rst grant_o[%0d]", n), 32'(grant_o[n]), 32'd0);
            chk($sformatf("rst data_o[%0d]", n), 32'(data_o[n]), 32'd0);
        end
        @(posedge clk);
        @(negedge clk);
        reset_n_i = 1'b1;
        #1;
    endtask

    localparam logic [31:0] D = 32'h13121110;

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();
        check_outputs();

        // all channels valid, full throughput: 10,11,12,13,10
        for (int k = 0; k < 5; k++) begin
            step(4'b1111, 4'b1111, 1'b1, D);
            chk("t1 data", 32'(data_o[0]), 32'h10 + 32'(k % 4));
            chk("t1 grant", 32'(grant_o[0]), 32'(4'b0001 << (k % 4)));
        end
        // backpressure: register and pointer freeze
        for (int k = 0; k < 5; k++) begin
            step(4'b1111, 4'b1111, 1'b0, D);
            chk("t2 hold", 32'(data_o[0]), 32'h10);
            chk("t2 ready", 32'(ready_o[0]), 32'h0);
        end
        step(4'b1111, 4'b1111, 1'b1, D);
        chk("t2 resume", 32'(data_o[0]), 32'h11);
        step(4'b1111, 4'b1111, 1'b1, D);
        chk("t2 resume2", 32'(data_o[0]), 32'h12);

        // wrap: ch2 alone, then ch0+ch2 -> ch0, ch2
        do_reset();
        step(4'b0100, 4'b1111, 1'b1, D);
        chk("t3 a", 32'(data_o[0]), 32'h12);
        step(4'b0101, 4'b1111, 1'b1, D);
        chk("t3 b", 32'(data_o[0]), 32'h10);
        step(4'b0101, 4'b1111, 1'b1, D);
        chk("t3 c", 32'(data_o[0]), 32'h12);

        // packet lock on ch1 with ch0 and ch3 also valid
        do_reset();
        step(4'b0001, 4'b1111, 1'b1, D);
        chk("t4 pre", 32'(grant_o[1]), 32'b0001);
        step(4'b1011, 4'b0000, 1'b1, D);
        chk("t4 b1", 32'(grant_o[1]), 32'b0010);
        step(4'b1011, 4'b0000, 1'b1, D);
        chk("t4 b2", 32'(grant_o[1]), 32'b0010);
        step(4'b1001, 4'b0000, 1'b1, D);
        chk("t4 gap1", 32'(ready_o[1]), 32'h0);
        step(4'b1001, 4'b0000, 1'b1, D);
        chk("t4 gap2", 32'(v_o[1]), 32'h0);
        step(4'b1011, 4'b0010, 1'b1, D);
        chk("t4 b3", 32'(grant_o[1]), 32'b0010);
        chk("t4 last", 32'(last_o[1]), 32'h1);
        step(4'b1011, 4'b0000, 1'b1, D);
        chk("t4 next", 32'(grant_o[1]), 32'b1000);

        // reset mid-packet (u1 locked on ch3, v_o=1), async clear
        @(negedge clk);
        #2;
        do_reset();
        step(4'b1111, 4'b1111, 1'b1, D);
        chk("t5 prio", 32'(grant_o[1]), 32'b0001);
        step(4'b1111, 4'b1111, 1'b1, D);
        chk("t5 unlocked", 32'(grant_o[1]), 32'b0010);

        // randomized run
        for (int k = 0; k < 10000; k++)
            step(4'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0), $urandom);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
